lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_gen.sv | 113 +++++++++++
 tb/tb_lcd_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an RGB LCD panel: free-running h/v counters, pixel requests
// upstream, and a 3-stage sync/DE pipeline aligned with the returned RGB565 data.
module lcd_timing_gen #(
  parameter int unsigned H_SYNC   = 1,
  parameter int unsigned H_BACK   = 43,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned V_SYNC   = 1,
  parameter int unsigned V_BACK   = 12,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FRONT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        req,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  input  logic [15:0] rgb_in,
  output logic        lcd_de,
  output logic        lcd_hsync_n,
  output logic        lcd_vsync_n,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b
);

  localparam int unsigned HTotal    = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned VTotal    = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HActStart = H_SYNC + H_BACK;
  localparam int unsigned VActStart = V_SYNC + V_BACK;
  localparam int unsigned HActEnd   = HActStart + H_ACTIVE;
  localparam int unsigned VActEnd   = VActStart + V_ACTIVE;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic        h_wrap, v_wrap;
  logic        h_act, v_act, active, hsync, vsync, origin;

  // Stages 1 and 2 of the sync/DE delay; stage 3 is the panel outputs themselves.
  logic de_p1, de_p2, hs_n_p1, hs_n_p2, vs_n_p1, vs_n_p2;

  always_comb begin
    h_wrap = (hcnt_q == 11'(HTotal - 1));
    v_wrap = (vcnt_q == 10'(VTotal - 1));
    h_act  = (hcnt_q >= 11'(HActStart)) && (hcnt_q < 11'(HActEnd));
    v_act  = (vcnt_q >= 10'(VActStart)) && (vcnt_q < 10'(VActEnd));
    active = h_act && v_act;
    hsync  = (hcnt_q < 11'(H_SYNC));
    vsync  = (vcnt_q < 10'(V_SYNC));
    origin = (hcnt_q == '0) && (vcnt_q == '0);

    hcnt_d = h_wrap ? '0 : hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      vcnt_d = v_wrap ? '0 : vcnt_q + 10'd1;
    end

    // Coordinates hold their last value through blanking.
    x_d = x;
    y_d = y;
    if (active) begin
      x_d = hcnt_q - 11'(HActStart);
      y_d = vcnt_q - 10'(VActStart);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      req         <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      de_p1       <= 1'b0;
      de_p2       <= 1'b0;
      hs_n_p1     <= 1'b1;
      hs_n_p2     <= 1'b1;
      vs_n_p1     <= 1'b1;
      vs_n_p2     <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      req         <= active;
      x           <= x_d;
      y           <= y_d;
      frame_start <= origin;
      de_p1       <= active;
      de_p2       <= de_p1;
      hs_n_p1     <= ~hsync;
      hs_n_p2     <= hs_n_p1;
      vs_n_p1     <= ~vsync;
      vs_n_p2     <= vs_n_p1;
      lcd_de      <= de_p2;
      lcd_hsync_n <= hs_n_p2;
      lcd_vsync_n <= vs_n_p2;
      // rgb_in answers the request made one cycle earlier, so it lines up with de_p2.
      lcd_r       <= de_p2 ? rgb_in[15:11] : '0;
      lcd_g       <= de_p2 ? rgb_in[10:5]  : '0;
      lcd_b       <= de_p2 ? rgb_in[4:0]   : '0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomized self-checking bench for lcd_timing_gen using a small raster and an
// arithmetic model of position-in-frame versus cycles since reset release.
module tb_lcd_timing_gen;

  localparam int HS = 2, HB = 3, HA = 8, HF = 2;
  localparam int VS = 1, VB = 2, VA = 4, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int HSB = HS + HB;
  localparam int VSB = VS + VB;
  localparam int FIRST_REQ = VSB * HT + HSB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req, frame_start, lcd_de, lcd_hsync_n, lcd_vsync_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic [15:0] rgb_in = 16'hFFFF;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;

  int total = 0;
  int bad = 0;

  // Source model: 0 = coordinate hash with random garbage between requests, 1 = constant.
  int          src_mode = 1;
  logic [15:0] src_const = 16'hFFFF;
  logic [15:0] salt = 16'h0;
  logic        src_req = 1'b0;
  logic [10:0] src_x = '0;
  logic [9:0]  src_y = '0;

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .x(x), .y(y), .frame_start(frame_start),
    .rgb_in(rgb_in), .lcd_de(lcd_de), .lcd_hsync_n(lcd_hsync_n), .lcd_vsync_n(lcd_vsync_n),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int px, input int py);
    return salt ^ 16'(px * 37 + py * 101 + 7);
  endfunction

  // Reference model: t is the cycle index since reset release; t=0 is raster origin.
  function automatic int hpos(input int t);
    return t % HT;
  endfunction
  function automatic int vpos(input int t);
    return (t / HT) % VT;
  endfunction
  function automatic bit act(input int t);
    if (t < 0) return 1'b0;
    return hpos(t) >= HSB && hpos(t) < HSB + HA && vpos(t) >= VSB && vpos(t) < VSB + VA;
  endfunction
  function automatic bit exp_hsn(input int c);
    return (c < 3) ? 1'b1 : !(hpos(c - 3) < HS);
  endfunction
  function automatic bit exp_vsn(input int c);
    return (c < 3) ? 1'b1 : !(vpos(c - 3) < VS);
  endfunction
  function automatic bit exp_fs(input int c);
    return (c >= 1) && ((c - 1) % FT == 0);
  endfunction

  always @(posedge clk) begin
    #1;
    if (src_mode == 0) rgb_in = src_req ? pix(int'(src_x), int'(src_y)) : 16'($urandom);
    else               rgb_in = src_const;
    src_req = req;
    src_x   = x;
    src_y   = y;
  end

  // Stimulus only: holds reset for n edges and leaves the bench at the negedge of cycle 0.
  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    src_mode = 1;
    src_const = 16'hFFFF;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (req !== 1'b0 || lcd_de !== 1'b0 || lcd_hsync_n !== 1'b1 || lcd_vsync_n !== 1'b1 ||
          frame_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctrl: req=%b de=%b hsn=%b vsn=%b fs=%b, want 0 0 1 1 0",
                 req, lcd_de, lcd_hsync_n, lcd_vsync_n, frame_start);
      end
      total++;
      if ({lcd_r, lcd_g, lcd_b} !== 16'h0 || x !== 11'd0 || y !== 10'd0) begin
        bad++;
        $display("FAIL reset_data: rgb=%h x=%0d y=%0d, want 0 0 0", {lcd_r, lcd_g, lcd_b}, x, y);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_first_pixel();
    int c;
    bit seen;
    src_mode = 1;
    src_const = 16'hF800;
    apply_reset(2);
    c = 0;
    seen = 1'b0;
    while (!seen && c < FT + 10) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (req === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || c != FIRST_REQ || x !== 11'd0 || y !== 10'd0) begin
      bad++;
      $display("FAIL first_req: seen=%b cycle=%0d x=%0d y=%0d, want cycle=%0d x=0 y=0",
               seen, c, x, y, FIRST_REQ);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (lcd_de !== 1'b1 || lcd_r !== 5'd31 || lcd_g !== 6'd0 || lcd_b !== 5'd0) begin
      bad++;
      $display("FAIL first_pixel: de=%b r=%0d g=%0d b=%0d, want 1 31 0 0",
               lcd_de, lcd_r, lcd_g, lcd_b);
    end
  endtask

  task automatic test_raster();
    logic [10:0] ex;
    logic [9:0]  ey;
    logic [15:0] ergb;
    bit          ede;
    salt = 16'($urandom);
    src_mode = 0;
    apply_reset(1 + $urandom_range(0, 3));
    ex = '0;
    ey = '0;
    for (int c = 0; c < 2 * FT + 20; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (act(c - 1)) begin
        ex = 11'(hpos(c - 1) - HSB);
        ey = 10'(vpos(c - 1) - VSB);
      end
      ede  = act(c - 3);
      ergb = ede ? pix(hpos(c - 3) - HSB, vpos(c - 3) - VSB) : 16'h0;
      total++;
      if (req !== act(c - 1) || frame_start !== exp_fs(c) || x !== ex || y !== ey) begin
        bad++;
        $display("FAIL raster_req c=%0d: req=%b fs=%b x=%0d y=%0d, want %b %b %0d %0d",
                 c, req, frame_start, x, y, act(c - 1), exp_fs(c), ex, ey);
      end
      total++;
      if (lcd_de !== ede || lcd_hsync_n !== exp_hsn(c) || lcd_vsync_n !== exp_vsn(c) ||
          {lcd_r, lcd_g, lcd_b} !== ergb) begin
        bad++;
        $display("FAIL raster_out c=%0d: de=%b hsn=%b vsn=%b rgb=%h, want %b %b %b %h",
                 c, lcd_de, lcd_hsync_n, lcd_vsync_n, {lcd_r, lcd_g, lcd_b},
                 ede, exp_hsn(c), exp_vsn(c), ergb);
      end
    end
  endtask

  task automatic test_line_frame();
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, run, hs_run, hs_fall;
    bit prev_de, prev_hsn;
    logic [10:0] lx;
    logic [9:0]  ly;
    logic [15:0] ergb;
    src_mode = 1;
    src_const = 16'hFFFF;
    apply_reset(1);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; run = 0; hs_run = 0; hs_fall = -1000;
    prev_de = 1'b0;
    prev_hsn = 1'b1;
    lx = '0;
    ly = '0;
    for (int c = 0; c <= FT + 2; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      ergb = act(c - 3) ? 16'hFFFF : 16'h0;
      total++;
      if ({lcd_r, lcd_g, lcd_b} !== ergb) begin
        bad++;
        $display("FAIL masking c=%0d: rgb=%h, want %h", c, {lcd_r, lcd_g, lcd_b}, ergb);
      end
      if (lcd_de === 1'b1) begin
        de_cnt++;
        run++;
        if (!prev_de) begin
          total++;
          if (c - hs_fall != HSB) begin
            bad++;
            $display("FAIL hs_to_de c=%0d: gap=%0d, want %0d", c, c - hs_fall, HSB);
          end
        end
      end else if (prev_de) begin
        total++;
        if (run != HA) begin
          bad++;
          $display("FAIL de_run c=%0d: run=%0d, want %0d", c, run, HA);
        end
        run = 0;
      end
      if (lcd_hsync_n === 1'b0) begin
        hs_cnt++;
        hs_run++;
        if (prev_hsn) hs_fall = c;
      end else if (!prev_hsn) begin
        total++;
        if (hs_run != HS) begin
          bad++;
          $display("FAIL hs_width c=%0d: width=%0d, want %0d", c, hs_run, HS);
        end
        hs_run = 0;
      end
      if (lcd_vsync_n === 1'b0) vs_cnt++;
      if (frame_start === 1'b1 && c >= 2) fs_cnt++;
      if (req === 1'b1) begin
        lx = x;
        ly = y;
      end
      prev_de = (lcd_de === 1'b1);
      prev_hsn = (lcd_hsync_n !== 1'b0);
    end
    total++;
    if (de_cnt != HA * VA || hs_cnt != HS * VT || vs_cnt != VS * HT || fs_cnt != 1) begin
      bad++;
      $display("FAIL frame_counts: de=%0d hs=%0d vs=%0d fs=%0d, want %0d %0d %0d 1",
               de_cnt, hs_cnt, vs_cnt, fs_cnt, HA * VA, HS * VT, VS * HT);
    end
    total++;
    if (lx !== 11'(HA - 1) || ly !== 10'(VA - 1)) begin
      bad++;
      $display("FAIL last_req: x=%0d y=%0d, want %0d %0d", lx, ly, HA - 1, VA - 1);
    end
  endtask

  task automatic test_mid_frame_reset();
    int tx, ty, t;
    salt = 16'($urandom);
    src_mode = 0;
    for (int k = 0; k < 4; k++) begin
      apply_reset(1);
      tx = $urandom_range(0, HA - 1);
      ty = $urandom_range(0, VA - 1);
      t  = (VSB + ty) * HT + HSB + tx;
      repeat (t + 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      total++;
      if (req !== 1'b1 || x !== 11'(tx) || y !== 10'(ty)) begin
        bad++;
        $display("FAIL mid_target: req=%b x=%0d y=%0d, want 1 %0d %0d", req, x, y, tx, ty);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (lcd_de !== 1'b0 || req !== 1'b0 || lcd_hsync_n !== 1'b1 || lcd_vsync_n !== 1'b1 ||
          {lcd_r, lcd_g, lcd_b} !== 16'h0 || x !== 11'd0 || y !== 10'd0) begin
        bad++;
        $display("FAIL mid_reset: de=%b req=%b hsn=%b vsn=%b rgb=%h x=%0d y=%0d",
                 lcd_de, req, lcd_hsync_n, lcd_vsync_n, {lcd_r, lcd_g, lcd_b}, x, y);
      end
      reset = 1'b0;
      for (int c = 0; c <= FIRST_REQ + 2; c++) begin
        if (c > 0) begin
          @(posedge clk);
          @(negedge clk);
        end
        total++;
        if (req !== (c == FIRST_REQ || c == FIRST_REQ + 1 || c == FIRST_REQ + 2) ||
            lcd_de !== (c == FIRST_REQ + 2)) begin
          bad++;
          $display("FAIL restart c=%0d: req=%b de=%b, want req from %0d de from %0d",
                   c, req, lcd_de, FIRST_REQ, FIRST_REQ + 2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_raster();
    test_line_frame();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
